// File: rtl/ifu.sv
// ifu: instruction fetch unit for the MIPS core.
//
// This unit holds the PC and the instruction register. It fetches one word at a time over a
// req/ack handshake. While the word is held, it exposes the decode fields to the control
// decoder. When the core retires the instruction (Advance), it commits the decoder's NPCOp.
//
// Parameters:
//   RESET_PC    PC value loaded on reset.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   iReq, iAddr              instruction memory request and byte address
//   iAck, iRData             memory acknowledge and returned word
//   Advance, NPCOp, RA       retire strobe, next-PC select, jump-register value
//   InstrValid, Instr        instruction register and its valid flag
//   OP, Funct, Imm16         decode slices of Instr
//   PC, PC4                  address of Instr and its link value
//   Fault                    misaligned jump-register target trapped
//
// Build option:
//   IFU_ALIGN_CHECK_EN  When this macro is defined, a misaligned jump-register target moves
//                       the unit into a sticky FAULT state. When it is undefined, the low two
//                       bits of the target are dropped and Fault is tied to 0.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        iReq,
    output logic [31:0] iAddr,
    input  logic        iAck,
    input  logic [31:0] iRData,
    input  logic        Advance,
    input  logic [1:0]  NPCOp,
    input  logic [31:0] RA,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [5:0]  OP,
    output logic [5:0]  Funct,
    output logic [15:0] Imm16,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        Fault
);

`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [1:0] {StRst, StFetch, StHold, StFault} state_e;
`else
    typedef enum logic [1:0] {StRst, StFetch, StHold} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4;
    logic [31:0] npc;

    assign pc4 = pc_q + 32'd4;

    // Next-PC candidates. All sums wrap modulo 2^32.
    always_comb begin
        npc = pc4;
        unique case (NPCOp)
            2'b00: npc = pc4;
            2'b01: npc = pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
            2'b10: npc = {pc4[31:28], instr_q[25:0], 2'b00};
            // In the checked build a misaligned RA never commits, so the mask is harmless.
            2'b11: npc = RA & 32'hFFFF_FFFC;
            default: npc = pc4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRst;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        iReq       = 1'b0;
        InstrValid = 1'b0;
        Fault      = 1'b0;
        unique case (state_q)
            StRst: begin
                state_d = StFetch;
            end
            StFetch: begin
                iReq = 1'b1;
                if (iAck) begin
                    instr_d = iRData;
                    state_d = StHold;
                end
            end
            StHold: begin
                InstrValid = 1'b1;
                if (Advance) begin
`ifdef IFU_ALIGN_CHECK_EN
                    if (NPCOp == 2'b11 && RA[1:0] != 2'b00) begin
                        state_d = StFault;
                    end else begin
                        pc_d    = npc;
                        state_d = StFetch;
                    end
`else
                    pc_d    = npc;
                    state_d = StFetch;
`endif
                end
            end
`ifdef IFU_ALIGN_CHECK_EN
            StFault: begin
                // Sticky until rst. PC keeps the address of the faulting jr.
                Fault = 1'b1;
            end
`endif
            default: begin
                state_d = StRst;
            end
        endcase
    end

    // The address only changes on Advance, so it is stable for the whole request.
    assign iAddr = pc_q;
    assign PC    = pc_q;
    assign PC4   = pc4;
    assign Instr = instr_q;
    assign OP    = instr_q[31:26];
    assign Funct = instr_q[5:0];
    assign Imm16 = instr_q[15:0];

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iReq;
    logic [31:0] iAddr;
    logic        iAck = 1'b0;
    logic [31:0] iRData = '0;
    logic        Advance = 1'b0;
    logic [1:0]  NPCOp = 2'b00;
    logic [31:0] RA = '0;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [5:0]  OP;
    logic [5:0]  Funct;
    logic [15:0] Imm16;
    logic [31:0] PC;
    logic [31:0] PC4;
    logic        Fault;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sbq[$];

    ifu #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRData(iRData),
        .Advance(Advance), .NPCOp(NPCOp), .RA(RA), .InstrValid(InstrValid), .Instr(Instr),
        .OP(OP), .Funct(Funct), .Imm16(Imm16), .PC(PC), .PC4(PC4), .Fault(Fault)
    );

    always #5 clk = ~clk;

    // Pulse Advance for one cycle; returns at the following negedge.
    task automatic advance(input logic [1:0] op, input logic [31:0] ra);
        Advance = 1'b1;
        NPCOp   = op;
        RA      = ra;
        @(negedge clk);
        Advance = 1'b0;
        NPCOp   = 2'b00;
        RA      = '0;
    endtask

    // Memory model: wait (bounded) for iReq, then ack after lat cycles. Reports
    // the address seen, whether it stayed stable, and whether iReq never came.
    task automatic fetch(input logic [31:0] word, input int lat, output bit timeout,
                         output bit stable, output logic [31:0] addr);
        int n = 0;
        timeout = 1'b0;
        stable  = 1'b1;
        addr    = '0;
        while (iReq !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (iReq !== 1'b1) begin
            timeout = 1'b1;
            return;
        end
        addr = iAddr;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (iReq !== 1'b1 || iAddr !== addr) stable = 1'b0;
        end
        iAck   = 1'b1;
        iRData = word;
        @(negedge clk);
        iAck   = 1'b0;
        iRData = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (PC !== 32'h3000) begin miscompares++;
            $display("FAIL reset_pc: got %h want %h", PC, 32'h3000); end
        vectors++; if (PC4 !== 32'h3004) begin miscompares++;
            $display("FAIL reset_pc4: got %h want %h", PC4, 32'h3004); end
        vectors++; if (iReq !== 1'b0 || iAddr !== 32'h3000) begin miscompares++;
            $display("FAIL reset_req: got req=%b addr=%h want 0/3000", iReq, iAddr); end
        vectors++; if (Instr !== 32'h0 || InstrValid !== 1'b0 || Fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_instr: got instr=%h v=%b f=%b want 0/0/0",
                     Instr, InstrValid, Fault); end
        vectors++; if (OP !== 6'h0 || Funct !== 6'h0 || Imm16 !== 16'h0) begin miscompares++;
            $display("FAIL reset_fields: got %h %h %h want 0", OP, Funct, Imm16); end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch();
        exp_t e;
        @(negedge clk);
        vectors++; if (iReq !== 1'b1 || iAddr !== 32'h3000) begin miscompares++;
            $display("FAIL first_req: got req=%b addr=%h want 1/3000", iReq, iAddr); end
        sbq.push_back('{pc: 32'h3000, instr: 32'h3C01_1234});
        iAck   = 1'b1;
        iRData = 32'h3C01_1234;
        @(negedge clk);
        iAck   = 1'b0;
        iRData = '0;
        e = sbq.pop_front();
        vectors++; if (InstrValid !== 1'b1 || Instr !== e.instr || PC !== e.pc) begin
            miscompares++;
            $display("FAIL first_hold: got v=%b instr=%h pc=%h want 1/%h/%h",
                     InstrValid, Instr, PC, e.instr, e.pc); end
        vectors++; if (OP !== 6'h0F || Imm16 !== 16'h1234 || Funct !== 6'h34) begin
            miscompares++;
            $display("FAIL first_fields: got op=%h imm=%h fn=%h want 0f/1234/34",
                     OP, Imm16, Funct); end
        // Advance in the first valid cycle: 2 cycles per instruction.
        advance(2'b00, 32'h0);
        vectors++; if (iReq !== 1'b1 || iAddr !== 32'h3004 || InstrValid !== 1'b0) begin
            miscompares++;
            $display("FAIL first_adv: got req=%b addr=%h v=%b want 1/3004/0",
                     iReq, iAddr, InstrValid); end
    endtask

    task automatic test_sequential();
        logic [31:0] pc = 32'h3004;
        logic [31:0] addr;
        bit to, st;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            sbq.push_back('{pc: pc, instr: 32'h2000_0000 + k});
            fetch(32'h2000_0000 + k, 3, to, st, addr);
            e = sbq.pop_front();
            vectors++; if (to || !st || addr !== e.pc) begin miscompares++;
                $display("FAIL seq_req%0d: got timeout=%b stable=%b addr=%h want 0/1/%h",
                         k, to, st, addr, e.pc); end
            vectors++; if (InstrValid !== 1'b1 || Instr !== e.instr || PC !== e.pc) begin
                miscompares++;
                $display("FAIL seq_hold%0d: got v=%b instr=%h pc=%h want 1/%h/%h",
                         k, InstrValid, Instr, PC, e.instr, e.pc); end
            advance(2'b00, 32'h0);
            pc = pc + 32'd4;
        end
        vectors++; if (iAddr !== 32'h3010) begin miscompares++;
            $display("FAIL seq_end: got %h want %h", iAddr, 32'h3010); end
    endtask

    task automatic test_ignored_inputs();
        logic [31:0] addr;
        bit to, st;
        // Advance while fetching must not move the PC.
        Advance = 1'b1;
        NPCOp   = 2'b11;
        RA      = 32'h0000_5000;
        @(negedge clk);
        Advance = 1'b0;
        NPCOp   = 2'b00;
        RA      = '0;
        vectors++; if (iReq !== 1'b1 || iAddr !== 32'h3010 || InstrValid !== 1'b0) begin
            miscompares++;
            $display("FAIL adv_in_fetch: got req=%b addr=%h v=%b want 1/3010/0",
                     iReq, iAddr, InstrValid); end
        fetch(32'hAAAA_0001, 0, to, st, addr);
        // A stray ack while holding must not overwrite Instr.
        iAck   = 1'b1;
        iRData = 32'hDEAD_BEEF;
        @(negedge clk);
        iAck   = 1'b0;
        iRData = '0;
        vectors++; if (Instr !== 32'hAAAA_0001 || InstrValid !== 1'b1 || PC !== 32'h3010) begin
            miscompares++;
            $display("FAIL ack_in_hold: got instr=%h v=%b pc=%h want aaaa0001/1/3010",
                     Instr, InstrValid, PC); end
        // rst beats a simultaneous Advance.
        rst     = 1'b1;
        Advance = 1'b1;
        NPCOp   = 2'b01;
        @(negedge clk);
        rst     = 1'b0;
        Advance = 1'b0;
        NPCOp   = 2'b00;
        vectors++; if (PC !== 32'h3000 || InstrValid !== 1'b0 || Instr !== 32'h0 ||
                       iReq !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_in_hold: got pc=%h v=%b instr=%h req=%b want 3000/0/0/0",
                     PC, InstrValid, Instr, iReq); end
        // rst mid-fetch beats a simultaneous iAck and drops the request.
        @(negedge clk);
        rst    = 1'b1;
        iAck   = 1'b1;
        iRData = 32'h1234_5678;
        @(negedge clk);
        rst    = 1'b0;
        iAck   = 1'b0;
        iRData = '0;
        vectors++; if (iReq !== 1'b0 || PC !== 32'h3000 || Instr !== 32'h0 ||
                       InstrValid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_in_fetch: got req=%b pc=%h instr=%h v=%b want 0/3000/0/0",
                     iReq, PC, Instr, InstrValid); end
    endtask

    typedef struct packed {
        logic [31:0] target;
        logic [31:0] word;
        logic [1:0]  op;
        logic [31:0] ra;
        logic [31:0] nxt;
    } redir_t;

    logic [31:0] last_pc;

    task automatic test_redirect();
        redir_t tbl[6];
        logic [31:0] addr;
        bit to, st;
        exp_t e;
        tbl[0] = '{target: 32'h3010, word: 32'h1000_FFFC, op: 2'b01, ra: 32'h0,
                   nxt: 32'h3004};
        tbl[1] = '{target: 32'h3010, word: 32'h1000_0002, op: 2'b01, ra: 32'h0,
                   nxt: 32'h301C};
        tbl[2] = '{target: 32'h3020, word: 32'h0800_0C10, op: 2'b10, ra: 32'h0,
                   nxt: 32'h3040};
        tbl[3] = '{target: 32'h3020, word: 32'h0000_0008, op: 2'b11, ra: 32'h3100,
                   nxt: 32'h3100};
        tbl[4] = '{target: 32'hFFFF_FFFC, word: 32'h0, op: 2'b00, ra: 32'h0,
                   nxt: 32'h0};
        tbl[5] = '{target: 32'hFFFF_FFF0, word: 32'h1000_0004, op: 2'b01, ra: 32'h0,
                   nxt: 32'h4};
        for (int k = 0; k < 6; k++) begin
            fetch(32'h0, 1, to, st, addr);
            advance(2'b11, tbl[k].target);
            sbq.push_back('{pc: tbl[k].target, instr: tbl[k].word});
            fetch(tbl[k].word, k % 3, to, st, addr);
            e = sbq.pop_front();
            vectors++; if (to || addr !== e.pc || PC !== e.pc || Instr !== e.instr ||
                           PC4 !== e.pc + 32'd4) begin
                miscompares++;
                $display("FAIL redir_hold%0d: got to=%b addr=%h pc=%h instr=%h pc4=%h want %h/%h",
                         k, to, addr, PC, Instr, PC4, e.pc, e.instr); end
            advance(tbl[k].op, tbl[k].ra);
            vectors++; if (iReq !== 1'b1 || iAddr !== tbl[k].nxt) begin miscompares++;
                $display("FAIL redir_next%0d: got req=%b addr=%h want 1/%h",
                         k, iReq, iAddr, tbl[k].nxt); end
            last_pc = tbl[k].nxt;
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] addr;
        bit to, st;
        fetch(32'h0000_0008, 0, to, st, addr);
        vectors++; if (to || addr !== last_pc) begin miscompares++;
            $display("FAIL jr_setup: got to=%b addr=%h want 0/%h", to, addr, last_pc); end
        advance(2'b11, 32'h0000_3102);
`ifdef IFU_ALIGN_CHECK_EN
        for (int k = 0; k < 4; k++) begin
            vectors++; if (Fault !== 1'b1 || iReq !== 1'b0 || InstrValid !== 1'b0 ||
                           PC !== last_pc) begin
                miscompares++;
                $display("FAIL fault%0d: got f=%b req=%b v=%b pc=%h want 1/0/0/%h",
                         k, Fault, iReq, InstrValid, PC, last_pc); end
            Advance = 1'b1;
            iAck    = 1'b1;
            @(negedge clk);
            Advance = 1'b0;
            iAck    = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (Fault !== 1'b0 || PC !== 32'h3000) begin miscompares++;
            $display("FAIL fault_clear: got f=%b pc=%h want 0/3000", Fault, PC); end
`else
        vectors++; if (iReq !== 1'b1 || iAddr !== 32'h3100 || Fault !== 1'b0) begin
            miscompares++;
            $display("FAIL jr_mask: got req=%b addr=%h f=%b want 1/3100/0",
                     iReq, iAddr, Fault); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_sequential();
        test_ignored_inputs();
        test_redirect();
        test_misaligned();
        vectors++; if (sbq.size() != 0) begin miscompares++;
            $display("FAIL scoreboard_left: got %0d want 0", sbq.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
